// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching instruction fetch unit with a DEPTH-entry instruction/pc queue
module fetch_queue #(
  parameter int M_WIDTH    = 8,
  parameter int INST_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       redirect,
  input  logic [M_WIDTH-1:0]         redirect_pc,
  input  logic [M_WIDTH-1:0]         mem_data,
  input  logic                       mem_ready,
  output logic                       mem_req,
  output logic [M_WIDTH-1:0]         addr,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [M_WIDTH-1:0]         inst_pc,
  output logic                       inst_valid,
  input  logic                       inst_ack,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int BEATS = INST_WIDTH / M_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                state;
  logic [M_WIDTH-1:0]    fetch_pc;
  logic [M_WIDTH-1:0]    cur_pc;
  logic [BW-1:0]         beat;
  logic [INST_WIDTH-1:0] asm_q;
  logic [INST_WIDTH-1:0] push_data;
  logic [INST_WIDTH-1:0] q_inst [DEPTH];
  logic [M_WIDTH-1:0]    q_pc   [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  beat_done;
  logic                  last_beat;
  logic                  push;
  logic                  pop;

  assign beat_done  = mem_req && mem_ready;
  assign last_beat  = (beat == BW'(BEATS - 1));
  assign push       = (state == REQ) && beat_done && last_beat && !redirect;
  assign pop        = inst_valid && inst_ack && !redirect;
  assign count_next = count + CW'(push) - CW'(pop);

  // The final beat bypasses the assembly register so it can be pushed on its own edge.
  always_comb begin
    push_data = asm_q;
    push_data[int'(beat)*M_WIDTH +: M_WIDTH] = mem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      cur_pc   <= '0;
      beat     <= '0;
      asm_q    <= '0;
      mem_req  <= 1'b0;
      addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (en && (count < CW'(DEPTH))) begin
            state   <= REQ;
            mem_req <= 1'b1;
            addr    <= fetch_pc;
            cur_pc  <= fetch_pc;
            beat    <= '0;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            beat     <= '0;
            // A beat landing with the redirect is simply dropped; otherwise it must be drained.
            if (beat_done) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (beat_done) begin
            asm_q    <= push_data;
            fetch_pc <= fetch_pc + M_WIDTH'(1);
            addr     <= addr + M_WIDTH'(1);
            if (last_beat) begin
              beat <= '0;
              if (en && (count_next < CW'(DEPTH))) begin
                cur_pc <= fetch_pc + M_WIDTH'(1);
              end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
              end
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        DRAIN: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= push_data;
      q_pc[wr_ptr]   <= cur_pc;
    end
  end

  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - bench for fetch_queue: vector table, corner sequences, randomized run
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        mem_req;
  logic [7:0]  addr;
  logic [15:0] inst_out;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ack = 1'b0;
  logic [2:0]  count;

  logic [7:0]  rmem [256];
  int          mode = 0;
  int          waits = 3;
  logic        resp_ready = 1'b0;
  logic        man_ready = 1'b0;
  int          nvec = 0;
  int          nerr = 0;

  fetch_queue #(.M_WIDTH(8), .INST_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_req(mem_req), .addr(addr),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ack(inst_ack), .count(count)
  );

  always #5 clk = ~clk;

  assign mem_data  = rmem[addr];
  assign mem_ready = (mode == 3) ? man_ready : resp_ready;

  // Memory responder: mode 0 zero-wait, mode 1 fixed wait states, mode 3 driven by the test.
  initial begin
    int  wcnt;
    logic last_ready, last_req;
    wcnt = 0; last_ready = 1'b0; last_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) wcnt = 0;
      else if (last_ready && last_req) wcnt = mem_req ? 1 : 0;
      else wcnt = mem_req ? wcnt + 1 : 0;
      if (mode == 0) resp_ready = 1'b1;
      else if (mode == 1) resp_ready = mem_req && (wcnt > waits);
      else resp_ready = 1'b0;
      last_ready = mem_ready;
      last_req   = mem_req;
    end
  end

  function automatic logic [15:0] f_inst(input logic [7:0] pc);
    logic [7:0] p1;
    p1 = pc + 8'd1;
    return {rmem[p1], rmem[pc]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; redirect = 1'b0; inst_ack = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [2:0] c);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (count == c) break;
    end
  endtask

  typedef struct {
    logic        en;
    logic        ack;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic [2:0]  exp_count;
    logic [15:0] exp_inst;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vt [19];

  initial begin
    vt[0]  = '{1, 0, 1, 8'h00, 3'd0, 16'h0000, 8'h00};
    vt[1]  = '{1, 0, 1, 8'h01, 3'd0, 16'h0000, 8'h00};
    vt[2]  = '{1, 0, 1, 8'h02, 3'd1, 16'hA4A5, 8'h00};
    vt[3]  = '{1, 0, 1, 8'h03, 3'd1, 16'hA4A5, 8'h00};
    vt[4]  = '{1, 0, 1, 8'h04, 3'd2, 16'hA4A5, 8'h00};
    vt[5]  = '{1, 0, 1, 8'h05, 3'd2, 16'hA4A5, 8'h00};
    vt[6]  = '{1, 0, 1, 8'h06, 3'd3, 16'hA4A5, 8'h00};
    vt[7]  = '{1, 0, 1, 8'h07, 3'd3, 16'hA4A5, 8'h00};
    vt[8]  = '{1, 0, 0, 8'h08, 3'd4, 16'hA4A5, 8'h00};
    vt[9]  = '{1, 0, 0, 8'h08, 3'd4, 16'hA4A5, 8'h00};
    vt[10] = '{1, 1, 0, 8'h08, 3'd3, 16'hA6A7, 8'h02};
    vt[11] = '{1, 0, 1, 8'h08, 3'd3, 16'hA6A7, 8'h02};
    vt[12] = '{1, 0, 1, 8'h09, 3'd3, 16'hA6A7, 8'h02};
    vt[13] = '{1, 0, 0, 8'h0A, 3'd4, 16'hA6A7, 8'h02};
    vt[14] = '{0, 1, 0, 8'h0A, 3'd3, 16'hA0A1, 8'h04};
    vt[15] = '{0, 1, 0, 8'h0A, 3'd2, 16'hA2A3, 8'h06};
    vt[16] = '{0, 1, 0, 8'h0A, 3'd1, 16'hACAD, 8'h08};
    vt[17] = '{0, 1, 0, 8'h0A, 3'd0, 16'h0000, 8'h00};
    vt[18] = '{0, 1, 0, 8'h0A, 3'd0, 16'h0000, 8'h00};

    for (int i = 0; i < 256; i++) rmem[i] = 8'(i) ^ 8'hA5;

    // reset state
    @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", 32'(inst_out), 32'd0);
    check("rst_pc", 32'(inst_pc), 32'd0);

    // fill, pop one, refill, then drain the queue
    mode = 0;
    do_reset();
    for (int k = 0; k < 19; k++) begin
      en = vt[k].en; inst_ack = vt[k].ack;
      tick();
      check($sformatf("tbl%0d_req", k), 32'(mem_req), 32'(vt[k].exp_req));
      check($sformatf("tbl%0d_addr", k), 32'(addr), 32'(vt[k].exp_addr));
      check($sformatf("tbl%0d_count", k), 32'(count), 32'(vt[k].exp_count));
      check($sformatf("tbl%0d_valid", k), 32'(inst_valid), 32'(vt[k].exp_count != 0));
      check($sformatf("tbl%0d_inst", k), 32'(inst_out), 32'(vt[k].exp_inst));
      check($sformatf("tbl%0d_pc", k), 32'(inst_pc), 32'(vt[k].exp_pc));
      @(negedge clk);
    end
    inst_ack = 1'b0;

    // redirect + ack together with count=3, beat completing on the same edge
    do_reset();
    en = 1'b1;
    wait_count(3'd3);
    check("b_count3", 32'(count), 32'd3);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 8'h10; inst_ack = 1'b1;
    tick();
    check("b_count0", 32'(count), 32'd0);
    check("b_valid0", 32'(inst_valid), 32'd0);
    check("b_req0", 32'(mem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0; inst_ack = 1'b0;
    tick();
    check("b_addr10", {31'd0, mem_req} << 8 | 32'(addr), 32'h110);
    wait_count(3'd1);
    check("b_pc", 32'(inst_pc), 32'h10);
    check("b_inst", 32'(inst_out), 32'(f_inst(8'h10)));

    // redirect while a waited beat is pending -> drain
    mode = 1;
    do_reset();
    en = 1'b1;
    wait_count(3'd1);
    check("a_pending", {31'd0, mem_req} << 8 | 32'(addr), 32'h102);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    check("a_flush", 32'(count), 32'd0);
    check("a_drain", {31'd0, mem_req} << 8 | 32'(addr), 32'h102);
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!mem_req) break;
      check("a_hold", 32'(addr), 32'h02);
    end
    check("a_idle", {31'd0, mem_req} << 8 | 32'(count), 32'h000);
    tick();
    check("a_newaddr", {31'd0, mem_req} << 8 | 32'(addr), 32'h140);
    wait_count(3'd1);
    check("a_pc", 32'(inst_pc), 32'h40);
    check("a_inst", 32'(inst_out), 32'(f_inst(8'h40)));

    // address wrap from FF, and en=0 not interrupting a started instruction
    mode = 0;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    check("c_idle", 32'(mem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0; en = 1'b1;
    tick();
    check("c_addrff", {31'd0, mem_req} << 8 | 32'(addr), 32'h1FF);
    tick();
    check("c_addr00", 32'(addr), 32'h00);
    tick();
    check("c_pc", 32'(inst_pc), 32'hFF);
    check("c_inst", 32'(inst_out), 32'hA55A);
    check("c_next", {31'd0, mem_req} << 8 | 32'(addr), 32'h101);
    @(negedge clk);
    en = 1'b0;
    tick();
    tick();
    check("c_count2", {31'd0, mem_req} << 8 | 32'(count), 32'h002);
    @(negedge clk);
    inst_ack = 1'b1;
    tick();
    check("c_pc01", 32'(inst_pc), 32'h01);
    check("c_inst01", 32'(inst_out), 32'hA7A4);
    @(negedge clk);
    inst_ack = 1'b0;

    // asynchronous reset between edges mid-fetch
    do_reset();
    en = 1'b1;
    wait_count(3'd2);
    #2;
    rst = 1'b1;
    #1;
    check("d_req", 32'(mem_req), 32'd0);
    check("d_count", 32'(count), 32'd0);
    check("d_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("d_restart", {31'd0, mem_req} << 8 | 32'(addr), 32'h100);
    wait_count(3'd1);
    check("d_pc", 32'(inst_pc), 32'h00);

    // randomized run against a sequential-pc scoreboard
    begin
      logic [7:0] exp_pc;
      logic       prev_req, prev_ready;
      logic [7:0] prev_addr;
      int         pops;
      for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
      mode = 3;
      do_reset();
      exp_pc = 8'h00; pops = 0; prev_req = 1'b0; prev_ready = 1'b0; prev_addr = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (prev_req && !prev_ready)
          check("r_addr_hold", {31'd0, mem_req} << 8 | 32'(addr), {23'd0, 1'b1, prev_addr});
        en = ($urandom % 10) < 7;
        inst_ack = $urandom % 2;
        redirect = ($urandom % 32) == 0;
        redirect_pc = 8'($urandom);
        man_ready = ($urandom % 3) != 0;
        if (redirect) begin
          exp_pc = redirect_pc;
        end else if (inst_valid && inst_ack) begin
          check("r_pc", 32'(inst_pc), 32'(exp_pc));
          check("r_inst", 32'(inst_out), 32'(f_inst(exp_pc)));
          exp_pc = exp_pc + 8'd2;
          pops++;
        end
        prev_req = mem_req; prev_ready = man_ready; prev_addr = addr;
        @(negedge clk);
      end
      check("r_progress", 32'(pops > 200), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
